// File: rtl/hc_req_encoder16_pkg.sv
// rtl/hc_req_encoder16_pkg.sv - shared widths, state encodings and helpers for the request encoder
package hc_req_encoder16_pkg;

    localparam int REQ_NUM    = 16;
    localparam int REQ_CODE_W = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } req_state_e;

    function automatic logic [REQ_NUM-1:0] code_onehot(input logic [REQ_CODE_W-1:0] code);
        logic [REQ_NUM-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hc_prio_enc16.sv
// rtl/hc_prio_enc16.sv - combinational 16-to-4 priority encoder, highest index wins
module hc_prio_enc16
    import hc_req_encoder16_pkg::*;
(
    input  logic [REQ_NUM-1:0]    req,
    output logic [REQ_CODE_W-1:0] code,
    output logic                  any
);

    // Ascending scan so the last hit, the highest index, is what remains.
    always_comb begin
        code = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (req[i]) begin
                code = REQ_CODE_W'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/hc_req_encoder16.sv
// rtl/hc_req_encoder16.sv - active-low request collector, priority encoder and valid/ack code presenter
module hc_req_encoder16
    import hc_req_encoder16_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REQ_NUM-1:0]    req_n_i,
    input  logic [REQ_NUM-1:0]    mask_i,
    input  logic                  ack_i,
    output logic [REQ_CODE_W-1:0] code_o,
    output logic                  valid_o,
    output logic [REQ_NUM-1:0]    pend_o,
    output logic                  gs_n_o
);

    logic [REQ_NUM-1:0]    sync_q [SYNC_STAGES];
    logic [REQ_NUM-1:0]    prev_q;
    logic [REQ_NUM-1:0]    s;
    logic [REQ_NUM-1:0]    fall;
    logic [REQ_NUM-1:0]    clr;
    logic [REQ_NUM-1:0]    elig;
    logic [REQ_NUM-1:0]    pend_q;
    logic [REQ_CODE_W-1:0] sel_code;
    logic                  sel_any;
    req_state_e            state_q;

    // Inactive level is 1, so a line already low at reset release reads as one falling edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
            prev_q <= '1;
        end else begin
            sync_q[0] <= req_n_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign fall = EDGE_MODE ? (prev_q & ~s) : ~s;
    assign clr  = (ack_i && valid_o) ? code_onehot(code_o) : '0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= fall | (pend_q & ~clr);
        end
    end

    assign elig = pend_q & ~mask_i;

    hc_prio_enc16 u_prio (
        .req  (elig),
        .code (sel_code),
        .any  (sel_any)
    );

    // Once presented, the code is frozen until acked: no preemption, masking does not revoke.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            valid_o <= 1'b0;
            code_o  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_any) begin
                        code_o  <= sel_code;
                        valid_o <= 1'b1;
                        state_q <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ack_i) begin
                        valid_o <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pend_o = pend_q;
    assign gs_n_o = ~sel_any;

endmodule

// File: tb/tb_hc_req_encoder16.sv
// tb/tb_hc_req_encoder16.sv - self-checking bench for hc_req_encoder16 in edge and level modes
module tb_hc_req_encoder16;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req_n = 16'hFFFF;
    logic [15:0] mask  = 16'h0000;
    logic [1:0]  ack   = 2'b00;

    logic [3:0]  code [2];
    logic [1:0]  valid;
    logic [15:0] pend [2];
    logic [1:0]  gs_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hc_req_encoder16 #(.SYNC_STAGES(SYNC), .EDGE_MODE(1'b1)) u_edge (
        .clk_i(clk), .rst_n_i(rst_n), .req_n_i(req_n), .mask_i(mask), .ack_i(ack[0]),
        .code_o(code[0]), .valid_o(valid[0]), .pend_o(pend[0]), .gs_n_o(gs_n[0])
    );

    hc_req_encoder16 #(.SYNC_STAGES(SYNC), .EDGE_MODE(1'b0)) u_level (
        .clk_i(clk), .rst_n_i(rst_n), .req_n_i(req_n), .mask_i(mask), .ack_i(ack[1]),
        .code_o(code[1]), .valid_o(valid[1]), .pend_o(pend[1]), .gs_n_o(gs_n[1])
    );

    // Reference: the line value seen by the detector is the input delayed SYNC edges;
    // index 0 models edge mode, index 1 level mode.
    logic [15:0] mdl_d [SYNC] = '{default: 16'hFFFF};
    logic [15:0] mdl_prev     = 16'hFFFF;
    logic [15:0] m_pend [2]   = '{default: 16'h0000};
    logic        m_valid [2]  = '{default: 1'b0};
    logic [3:0]  m_code [2]   = '{default: 4'h0};

    function automatic int top_bit(input logic [15:0] x);
        return $clog2(int'(x) + 1) - 1;
    endfunction

    function automatic logic [15:0] new_req(input int m, input logic [15:0] s, input logic [15:0] prv);
        return (m == 0) ? (prv & ~s) : ~s;
    endfunction

    function automatic logic [15:0] served(input int m, input logic a, input logic v, input logic [3:0] c);
        return (a && v) ? (16'h0001 << c) : 16'h0000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < SYNC; j++) mdl_d[j] <= 16'hFFFF;
            mdl_prev <= 16'hFFFF;
            for (int m = 0; m < 2; m++) begin
                m_pend[m]  <= 16'h0000;
                m_valid[m] <= 1'b0;
                m_code[m]  <= 4'h0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                m_pend[m] <= new_req(m, mdl_d[SYNC-1], mdl_prev)
                           | (m_pend[m] & ~served(m, ack[m], m_valid[m], m_code[m]));
                if (!m_valid[m]) begin
                    if ((m_pend[m] & ~mask) != 16'h0000) begin
                        m_code[m]  <= 4'(top_bit(m_pend[m] & ~mask));
                        m_valid[m] <= 1'b1;
                    end
                end else if (ack[m]) begin
                    m_valid[m] <= 1'b0;
                end
            end
            mdl_d[0] <= req_n;
            for (int j = 1; j < SYNC; j++) mdl_d[j] <= mdl_d[j-1];
            mdl_prev <= mdl_d[SYNC-1];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            chk((m == 0) ? "model_valid_edge" : "model_valid_level", 32'(valid[m]), 32'(m_valid[m]));
            chk((m == 0) ? "model_code_edge"  : "model_code_level",  32'(code[m]),  32'(m_code[m]));
            chk((m == 0) ? "model_pend_edge"  : "model_pend_level",  32'(pend[m]),  32'(m_pend[m]));
            chk((m == 0) ? "model_gs_edge"    : "model_gs_level",    32'(gs_n[m]),
                32'(~|(m_pend[m] & ~mask)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int m, input int max_cycles);
        int n;
        n = 0;
        while (!valid[m] && n < max_cycles) begin
            tick();
            n++;
        end
        chk("wait_valid_timeout", 32'(valid[m]), 32'd1);
    endtask

    task automatic ack_once(input int m);
        ack[m] = 1'b1;
        tick();
        ack[m] = 1'b0;
    endtask

    task automatic settle();
        req_n = 16'hFFFF;
        mask  = 16'h0000;
        repeat (5) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req_n = 16'h0000;
        repeat (3) tick();
        chk("reset_code",  32'(code[0]),  32'h0);
        chk("reset_valid", 32'(valid[0]), 32'h0);
        chk("reset_pend",  32'(pend[0]),  32'h0);
        chk("reset_gs_n",  32'(gs_n[0]),  32'h1);

        // All lines held low across reset release: each pends once, served 15 down to 0.
        rst_n = 1'b1;
        for (int k = 15; k >= 0; k--) begin
            wait_valid(0, 10);
            chk("release_order", 32'(code[0]), 32'(k));
            ack_once(0);
        end
        chk("release_pend_empty", 32'(pend[0]),  32'h0);
        chk("release_valid_low",  32'(valid[0]), 32'h0);
        settle();

        // Single edge on line 5: pend at N+2, presented at N+3.
        req_n[5] = 1'b0;
        tick();
        tick();
        chk("edge5_pend_n1", 32'(pend[0]), 32'h0000);
        tick();
        chk("edge5_pend_n2",  32'(pend[0]),  32'h0020);
        chk("edge5_valid_n2", 32'(valid[0]), 32'h0);
        tick();
        chk("edge5_valid_n3", 32'(valid[0]), 32'h1);
        chk("edge5_code_n3",  32'(code[0]),  32'h5);
        ack_once(0);
        chk("edge5_pend_ack",  32'(pend[0]),  32'h0000);
        chk("edge5_valid_ack", 32'(valid[0]), 32'h0);
        settle();

        // Lines 3 and 12 together; later line 15 must not preempt.
        req_n = ~16'h1008;
        wait_valid(0, 10);
        chk("prio_first", 32'(code[0]), 32'd12);
        ack_once(0);
        chk("prio_bubble", 32'(valid[0]), 32'h0);
        tick();
        chk("prio_second_valid", 32'(valid[0]), 32'h1);
        chk("prio_second_code",  32'(code[0]),  32'd3);
        req_n[15] = 1'b0;
        repeat (4) tick();
        chk("prio_no_preempt_code",  32'(code[0]),  32'd3);
        chk("prio_no_preempt_pend",  32'(pend[0][15]), 32'h1);
        ack_once(0);
        tick();
        chk("prio_after_15", 32'(code[0]), 32'd15);
        ack_once(0);
        settle();

        // Masked line records but is not selected until unmasked.
        mask = 16'h0200;
        req_n[9] = 1'b0;
        repeat (4) tick();
        chk("mask_pend",  32'(pend[0]),  32'h0200);
        chk("mask_gs_n",  32'(gs_n[0]),  32'h1);
        chk("mask_valid", 32'(valid[0]), 32'h0);
        mask = 16'h0000;
        #1;
        chk("unmask_gs_n", 32'(gs_n[0]), 32'h0);
        tick();
        chk("unmask_valid", 32'(valid[0]), 32'h1);
        chk("unmask_code",  32'(code[0]),  32'd9);
        ack_once(0);
        settle();

        // New edge on line 7 lands its set in the same cycle as the ack of line 7.
        req_n[7] = 1'b0;
        wait_valid(0, 10);
        chk("coll_first", 32'(code[0]), 32'd7);
        req_n[7] = 1'b1;
        repeat (4) tick();
        req_n[7] = 1'b0;
        tick();
        tick();
        ack_once(0);
        chk("coll_pend_kept", 32'(pend[0]),  32'h0080);
        chk("coll_bubble",    32'(valid[0]), 32'h0);
        tick();
        chk("coll_represent_valid", 32'(valid[0]), 32'h1);
        chk("coll_represent_code",  32'(code[0]),  32'd7);
        ack_once(0);
        settle();

        // Level mode: line 2 held low is re-presented every 2 cycles.
        req_n = ~16'h0004;
        for (int n = 0; n < 60; n++) begin
            if (valid[1] && code[1] == 4'd2) break;
            if (valid[1]) ack_once(1);
            else tick();
        end
        for (int r = 0; r < 3; r++) begin
            chk("level_valid", 32'(valid[1]), 32'h1);
            chk("level_code",  32'(code[1]),  32'd2);
            ack_once(1);
            chk("level_bubble",    32'(valid[1]),   32'h0);
            chk("level_pend_held", 32'(pend[1][2]), 32'h1);
            tick();
        end
        chk("level_before_reset", 32'(valid[1]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid_level", 32'(valid[1]), 32'h0);
        chk("async_reset_pend_level",  32'(pend[1]),  32'h0);
        chk("async_reset_valid_edge",  32'(valid[0]), 32'h0);
        tick();
        tick();
        req_n = 16'hFFFF;
        rst_n = 1'b1;
        repeat (5) tick();

        // Randomised traffic, checked every cycle against the reference.
        for (int c = 0; c < 3000; c++) begin
            req_n = req_n ^ 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 15) == 0) mask = 16'($urandom & $urandom);
            ack[0] = 1'($urandom_range(0, 1));
            ack[1] = 1'($urandom_range(0, 1));
            tick();
        end
        ack = 2'b00;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
